// File: rtl/cache_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_arb_pkg
// Brief    : Shared types and widths for the cache port arbiter.
// Revision : 1.0  initial release
// ============================================================================
package cache_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        TURN = 2'd2
    } arb_state_t;

    localparam int LINE_BITS = 512;
    localparam int WORD_BITS = 64;
    localparam int ADDR_BITS = 64;
    localparam int PERF_BITS = 32;

endpackage
`default_nettype wire

// File: rtl/cache_port_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Brief    : Combinational round-robin picker: first set request at or after
//            rr_ptr, scanning upward with wrap.
// Revision : 1.0  initial release
// ============================================================================
module rr_pick
    import cache_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] rr_ptr,
    output logic [IDXW-1:0] winner,
    output logic            any
);

    // Scan from farthest to nearest so the closest set bit overwrites last.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                winner = IDXW'(j);
                any    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cache_port_arbiter
// Brief    : Round-robin sharing of one cache port between NREQ requesters,
//            with a turnaround cycle after every response.
//            Optional grant counters: define CACHE_ARB_PERF_EN.
// Revision : 1.0  initial release
// ============================================================================
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDXW = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req_cyc,
    input  logic [NREQ*ADDR_BITS-1:0] req_addr,
    input  logic [NREQ-1:0]           req_we,
    input  logic [NREQ*WORD_BITS-1:0] req_wdata,
    output logic [NREQ-1:0]           resp_cyc,
    output logic [LINE_BITS-1:0]      resp_data,
    output logic                      c_reqcyc,
    output logic [ADDR_BITS-1:0]      c_addr,
    output logic                      c_we,
    output logic [WORD_BITS-1:0]      c_wdata,
    input  logic                      c_respcyc,
    input  logic [LINE_BITS-1:0]      c_rdata,
    output logic [NREQ*PERF_BITS-1:0] perf_grants
);

    arb_state_t             r_state;
    arb_state_t             w_state_next;
    logic [IDXW-1:0]        r_rr_ptr;
    logic [IDXW-1:0]        r_grant;
    logic [IDXW-1:0]        w_winner;
    logic [IDXW-1:0]        w_ptr_next;
    logic                   w_any;
    logic                   w_grant_now;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_we;
    logic [WORD_BITS-1:0]   r_wdata;
    logic [NREQ-1:0]        r_resp_cyc;
    logic [LINE_BITS-1:0]   r_resp_data;
    logic [ADDR_BITS-1:0]   w_req_addr  [NREQ];
    logic [WORD_BITS-1:0]   w_req_wdata [NREQ];

    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_unpack
            assign w_req_addr[g]  = req_addr[ADDR_BITS*g +: ADDR_BITS];
            assign w_req_wdata[g] = req_wdata[WORD_BITS*g +: WORD_BITS];
        end
    endgenerate

    rr_pick #(
        .NREQ   (NREQ),
        .IDXW   (IDXW)
    ) u_rr_pick (
        .req    (req_cyc),
        .rr_ptr (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_grant_now = (r_state == IDLE) && w_any;

    always_comb begin
        w_ptr_next = '0;
        if (r_grant < IDXW'(NREQ - 1)) begin
            w_ptr_next = r_grant + IDXW'(1);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_any)     w_state_next = BUSY;
            BUSY:    if (c_respcyc) w_state_next = TURN;
            TURN:                   w_state_next = IDLE;
            default:                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Payload is captured once at grant; the cache port never sees live inputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_resp_cyc  <= '0;
            r_resp_data <= '0;
        end else begin
            r_resp_cyc <= '0;
            if (w_grant_now) begin
                r_grant <= w_winner;
                r_addr  <= w_req_addr[w_winner];
                r_we    <= req_we[w_winner];
                r_wdata <= w_req_wdata[w_winner];
            end
            if ((r_state == BUSY) && c_respcyc) begin
                r_resp_cyc[r_grant] <= 1'b1;
                r_resp_data         <= c_rdata;
                r_rr_ptr            <= w_ptr_next;
            end
        end
    end

    assign c_reqcyc  = (r_state == BUSY);
    assign c_addr    = r_addr;
    assign c_we      = r_we;
    assign c_wdata   = r_wdata;
    assign resp_cyc  = r_resp_cyc;
    assign resp_data = r_resp_data;

`ifdef CACHE_ARB_PERF_EN
    generate
        for (genvar g = 0; g < NREQ; g++) begin : g_perf
            logic [PERF_BITS-1:0] r_cnt;
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_cnt <= '0;
                end else if (w_grant_now && (w_winner == IDXW'(g)) && (r_cnt != '1)) begin
                    r_cnt <= r_cnt + PERF_BITS'(1);
                end
            end
            assign perf_grants[PERF_BITS*g +: PERF_BITS] = r_cnt;
        end
    endgenerate
`else
    assign perf_grants = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_port_arbiter
// Brief    : Scoreboard bench for cache_port_arbiter with a simple cache model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cache_port_arbiter;

    localparam int NREQ = 2;
    localparam int IDXW = 1;

    typedef struct {
        int          idx;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        int          lat;
    } exp_t;

    logic               clk;
    logic               reset;
    logic [NREQ-1:0]    req_cyc;
    logic [NREQ*64-1:0] req_addr;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*64-1:0] req_wdata;
    logic [NREQ-1:0]    resp_cyc;
    logic [511:0]       resp_data;
    logic               c_reqcyc;
    logic [63:0]        c_addr;
    logic               c_we;
    logic [63:0]        c_wdata;
    logic               c_respcyc;
    logic [511:0]       c_rdata;
    logic [NREQ*32-1:0] perf_grants;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   lat      = 3;
    int   want [NREQ];
    int   done [NREQ];

    cache_port_arbiter #(.NREQ(NREQ), .IDXW(IDXW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_cyc     (req_cyc),
        .req_addr    (req_addr),
        .req_we      (req_we),
        .req_wdata   (req_wdata),
        .resp_cyc    (resp_cyc),
        .resp_data   (resp_data),
        .c_reqcyc    (c_reqcyc),
        .c_addr      (c_addr),
        .c_we        (c_we),
        .c_wdata     (c_wdata),
        .c_respcyc   (c_respcyc),
        .c_rdata     (c_rdata),
        .perf_grants (perf_grants)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [511:0] line_of(input logic [63:0] a);
        logic [511:0] l;
        for (int w = 0; w < 8; w++) begin
            l[64*w +: 64] = {a[31:0], 32'hC0DE_0000 | 32'(w)};
        end
        return l;
    endfunction

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cache model: answers after `lat` cycles of c_reqcyc, junk data otherwise.
    initial begin
        int cnt;
        cnt       = 0;
        c_respcyc = 1'b0;
        c_rdata   = {16{32'hDEAD_BEEF}};
        forever begin
            @(negedge clk);
            c_respcyc = 1'b0;
            c_rdata   = {16{32'hDEAD_BEEF}};
            if (c_reqcyc === 1'b1) begin
                cnt++;
                if (cnt == lat) begin
                    c_respcyc = 1'b1;
                    c_rdata   = line_of(c_addr);
                    cnt       = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Requester driver: each requester stays high until it has seen `want` responses.
    initial begin
        req_cyc = '0;
        for (int i = 0; i < NREQ; i++) done[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (resp_cyc[i] === 1'b1) done[i]++;
                req_cyc[i] = (done[i] < want[i]);
            end
        end
    end

    // Monitor: checks cache-side payload each busy cycle and pops on responses.
    initial begin
        int           busy_cnt;
        logic [511:0] last_line;
        exp_t         e;
        logic [NREQ-1:0] oh;
        busy_cnt  = 0;
        last_line = '0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                busy_cnt  = 0;
                last_line = '0;
            end else begin
                if (c_reqcyc === 1'b1) begin
                    busy_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_c_reqcyc", 512'(c_reqcyc), 512'd0);
                    end else begin
                        e = exp_q[0];
                        chk("c_addr", 512'(c_addr), 512'(e.addr));
                        chk("c_we", 512'(c_we), 512'(e.we));
                        chk("c_wdata", 512'(c_wdata), 512'(e.wdata));
                    end
                end
                if (resp_cyc !== '0) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_resp_cyc", 512'(resp_cyc), 512'd0);
                    end else begin
                        e  = exp_q.pop_front();
                        oh = '0;
                        oh[e.idx] = 1'b1;
                        chk("resp_cyc", 512'(resp_cyc), 512'(oh));
                        chk("resp_data", resp_data, line_of(e.addr));
                        chk("busy_cycles", 512'(busy_cnt), 512'(e.lat));
                        chk("c_reqcyc_in_turn", 512'(c_reqcyc), 512'd0);
                        last_line = line_of(e.addr);
                        busy_cnt  = 0;
                    end
                end else begin
                    chk("resp_data_hold", resp_data, last_line);
                end
            end
        end
    end

    task automatic issue(input int idx, input logic [63:0] addr, input logic we,
                         input logic [63:0] wdata, input int l);
        exp_t e;
        e.idx = idx; e.addr = addr; e.we = we; e.wdata = wdata; e.lat = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || c_reqcyc !== 1'b0 || resp_cyc !== '0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) chk({name, "_timeout"}, 512'(exp_q.size()), 512'd0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic wait_reqcyc(input string name);
        int k;
        k = 0;
        while (c_reqcyc !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (k >= 50) chk({name, "_timeout"}, 512'(c_reqcyc), 512'd1);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_c_reqcyc"}, 512'(c_reqcyc), 512'd0);
        chk({tag, "_c_addr"}, 512'(c_addr), 512'd0);
        chk({tag, "_c_we"}, 512'(c_we), 512'd0);
        chk({tag, "_c_wdata"}, 512'(c_wdata), 512'd0);
        chk({tag, "_resp_cyc"}, 512'(resp_cyc), 512'd0);
        chk({tag, "_resp_data"}, resp_data, 512'd0);
        chk({tag, "_perf"}, 512'(perf_grants), 512'd0);
    endtask

    initial begin
        reset     = 1'b0;
        req_addr  = '0;
        req_we    = '0;
        req_wdata = '0;
        for (int i = 0; i < NREQ; i++) want[i] = 0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        #1 reset = 1'b1;

        // Contention from reset: rr_ptr = 0 so grants go 0,1,0,1.
        lat = 3;
        req_addr[63:0]   = 64'h100;
        req_addr[127:64] = 64'h200;
        issue(0, 64'h100, 1'b0, 64'h0, 3);
        issue(1, 64'h200, 1'b0, 64'h0, 3);
        issue(0, 64'h100, 1'b0, 64'h0, 3);
        issue(1, 64'h200, 1'b0, 64'h0, 3);
        want[0] = want[0] + 2;
        want[1] = want[1] + 2;
        wait_idle("contention");

        // Single read, five-cycle cache latency.
        lat = 5;
        req_addr[63:0] = 64'h1000;
        issue(0, 64'h1000, 1'b0, 64'h0, 5);
        want[0]++;
        wait_idle("single_read");

        // Payload stability: live inputs change while busy.
        lat = 6;
        req_addr[63:0] = 64'h2000;
        issue(0, 64'h2000, 1'b0, 64'h0, 6);
        want[0]++;
        wait_reqcyc("stability");
        repeat (2) @(negedge clk);
        #1;
        req_addr[63:0]  = 64'hDEAD;
        req_we[0]       = 1'b1;
        req_wdata[63:0] = 64'hFFFF_0000_FFFF_0000;
        wait_idle("stability");
        req_we[0]       = 1'b0;
        req_wdata[63:0] = '0;

        // Write from requester 1.
        lat = 4;
        req_addr[127:64]  = 64'h40;
        req_we[1]         = 1'b1;
        req_wdata[127:64] = 64'h1122_3344_5566_7788;
        issue(1, 64'h40, 1'b1, 64'h1122_3344_5566_7788, 4);
        want[1]++;
        wait_idle("write");
        req_we[1]         = 1'b0;
        req_wdata[127:64] = '0;

        // Move rr_ptr to 1, then abandon a transaction with reset.
        lat = 3;
        req_addr[63:0] = 64'h1800;
        issue(0, 64'h1800, 1'b0, 64'h0, 3);
        want[0]++;
        wait_idle("pre_reset");
        lat = 20;
        issue(0, 64'h1800, 1'b0, 64'h0, 20);
        want[0]++;
        wait_reqcyc("mid_busy");
        repeat (2) @(negedge clk);
        #1;
        reset   = 1'b0;
        want[0] = done[0];
        exp_q.delete();
        @(negedge clk);
        check_all_zero("mid_reset");
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_resp_cyc", 512'(resp_cyc), 512'd0);

        // Both requesters after reset: rr_ptr back at 0 so requester 0 wins first.
        #1;
        lat = 3;
        req_addr[63:0]   = 64'h3000;
        req_addr[127:64] = 64'h4000;
        issue(0, 64'h3000, 1'b0, 64'h0, 3);
        issue(1, 64'h4000, 1'b0, 64'h0, 3);
        want[0]++;
        want[1]++;
        wait_idle("post_reset_rr");
        issue(0, 64'h3000, 1'b0, 64'h0, 3);
        want[0]++;
        wait_idle("single0_a");
        issue(1, 64'h4000, 1'b0, 64'h0, 3);
        want[1]++;
        wait_idle("single1");
        issue(0, 64'h3000, 1'b0, 64'h0, 3);
        want[0]++;
        wait_idle("single0_b");

`ifdef CACHE_ARB_PERF_EN
        chk("perf_grants", 512'(perf_grants), 512'({32'd2, 32'd3}));
`else
        chk("perf_grants", 512'(perf_grants), 512'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_port_arbiter.md
Name: cache_port_arbiter

Overview:
- Shares one set-associative read/write cache port between NREQ requesters, e.g. fetch, load/store and page walker.
- Round-robin arbitration picks one requester. The arbiter latches that request's address, write flag and write data, and holds them stable on the cache port until the cache's one-cycle respcyc pulse.
- It then returns the 512-bit line to the winner and inserts one turnaround cycle so the cache is back in idle before the next grant.
- Sits between core-side requesters and the cache's reqcyc/addr/writeEnable/write_data/respcyc/read_data interface.

Parameters:
- NREQ, 2, number of requesters (2..8).
- IDXW, 1, width of the grant index; must equal max(1, ceil(log2 NREQ)).

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- req_cyc  in  NREQ  per-requester request level; held high until that requester's resp_cyc.
- req_addr  in  NREQ*64  per-requester byte address; slice i = [64*i+63:64*i].
- req_we  in  NREQ  1 = write of one 64-bit word, 0 = line read.
- req_wdata  in  NREQ*64  per-requester write word; slice i as req_addr.
- resp_cyc  out  NREQ  one-cycle completion pulse, one-hot or zero.
- resp_data  out  512  line data for reads; valid only while some resp_cyc bit is 1.
- c_reqcyc  out  1  to cache reqcyc.
- c_addr  out  64  to cache addr.
- c_we  out  1  to cache writeEnable.
- c_wdata  out  64  to cache write_data.
- c_respcyc  in  1  from cache respcyc; one-cycle pulse.
- c_rdata  in  512  from cache read_data.
- perf_grants  out  NREQ*32  per-requester grant counters; see Optional Feature.

Behaviour:
- Reset (reset == 0 at posedge):
  - state = IDLE, rr_ptr = 0, grant index = 0.
  - Payload registers cleared; c_reqcyc, c_addr, c_we, c_wdata, resp_cyc, resp_data all 0.
- States: IDLE, BUSY, TURN.
- IDLE:
  - If any req_cyc bit is set, choose the first set bit at or after rr_ptr, scanning upward with wrap modulo NREQ.
  - Latch that requester's addr/we/wdata and its index; go to BUSY.
  - With no requests, stay in IDLE with c_reqcyc = 0.
- BUSY:
  - c_reqcyc = 1; c_addr/c_we/c_wdata driven only from the latched registers, never from live req_* inputs.
  - Payload stays stable for the whole transaction, including misses, evictions and refills of any length.
  - No timeout; wait indefinitely for c_respcyc.
  - On c_respcyc = 1:
    - Register resp_cyc[grant] = 1 and resp_data = c_rdata, visible the next cycle.
    - rr_ptr = (grant + 1) mod NREQ; c_reqcyc = 0 the next cycle; go to TURN.
- TURN:
  - Exactly one cycle; resp_cyc pulse visible here, c_reqcyc = 0; go to IDLE.
  - The granted requester must drop req_cyc in this cycle. If it stays high it is treated as a new request in IDLE, subject to rr order.
- Latency: grant registered in the cycle req_cyc is seen in IDLE. c_reqcyc rises 1 cycle after req_cyc; resp_cyc arrives 1 cycle after c_respcyc. Minimum issue spacing is request -> BUSY -> ... -> TURN -> IDLE.
- Simultaneous events:
  - A new req_cyc arriving during BUSY/TURN is held pending and not dropped.
  - c_respcyc outside BUSY is ignored.
- Write responses: resp_data still carries c_rdata; consumers ignore it.
- resp_data holds its last value between pulses.
- Reset mid-BUSY: transaction abandoned, no resp_cyc. The cache shares the same reset.
- NREQ = 1: degenerates to pass-through with a TURN cycle; rr_ptr stays 0.

Optional Feature:
- Macro CACHE_ARB_PERF_EN.
- Defined: one 32-bit counter per requester, incremented on each IDLE->BUSY grant to that requester.
  - Saturates at 32'hFFFF_FFFF; cleared by reset.
  - Exported on perf_grants, slice i = [32*i+31:32*i].
- Undefined: no counter flops; perf_grants tied to 0; port list unchanged.

Decomposition:
- Package cache_arb_pkg:
  - enum arb_state_t {IDLE, BUSY, TURN};
  - localparams LINE_BITS = 512, WORD_BITS = 64, ADDR_BITS = 64, PERF_BITS = 32.
- Sub-module rr_pick (combinational):
  - Inputs: req vector, rr_ptr.
  - Outputs: winner index, any.
  - Instantiated once; reusable by other arbiters.

Test Plan:
- Single read: req_cyc = 2'b01, addr 0x1000, cache answers c_respcyc 5 cycles later with c_rdata = pattern A -> c_reqcyc high for 5 cycles with c_addr = 0x1000, c_we = 0; resp_cyc = 2'b01 one cycle after with resp_data = A; then TURN, then IDLE.
- Contention: both requesters high from cycle 0, each cache op 3 cycles -> grants alternate 0, 1, 0, 1; no requester waits more than one transaction.
- Payload stability: change req_addr[0] to 0xDEAD during BUSY -> c_addr stays at the latched 0x2000 until c_respcyc.
- Write: req_we[1] = 1, addr 0x40, wdata 64'h1122_3344_5566_7788 -> c_we = 1, c_wdata matches; resp_cyc = 2'b10.
- Reset mid-BUSY: reset low for one cycle at BUSY+2 -> all outputs 0 next cycle, no resp_cyc; rr_ptr = 0.
- CACHE_ARB_PERF_EN: 3 grants to requester 0, 2 to requester 1 -> perf_grants = {32'd2, 32'd3}. Macro undefined -> perf_grants = 0.
